// File: rtl/tlb_pkg.sv
// Shared widths, page-table entry layout, FSM encoding and TLB entry
// type for the virtual-to-physical translation stage.
package tlb_pkg;

    localparam int VA_W  = 14;
    localparam int PA_W  = 10;
    localparam int OFF_W = 6;
    localparam int VPN_W = 8;
    localparam int PPN_W = 4;

    localparam int TLB_N = 4;
    localparam int IDX_W = 2;
    localparam int PT_N  = 256;
    localparam int PTE_W = 7;
    localparam int CNT_W = 4;

    // Page-table entry: {valid, dirty, ref, ppn[3:0]}
    localparam int PTE_V = 6;
    localparam int PTE_D = 5;
    localparam int PTE_R = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_WALK    = 3'd2,
        ST_REFILL  = 3'd3,
        ST_RESPOND = 3'd4,
        ST_FAULT   = 3'd5
    } tlb_state_e;

    typedef struct packed {
        logic             v;
        logic             d;
        logic             r;
        logic [VPN_W-1:0] vpn;
        logic [PPN_W-1:0] ppn;
    } tlb_entry_t;

    function automatic logic [PTE_W-1:0] make_pte(
        input logic             v,
        input logic             d,
        input logic             r,
        input logic [PPN_W-1:0] ppn
    );
        return {v, d, r, ppn};
    endfunction

endpackage

// File: rtl/tlb_lru_tracker.sv
// True-LRU age tracker for the 4-entry TLB.
// Ports: clk_i/rst_i, touch_i + touch_idx_i (access or install),
// valid_i (entry valid bits), victim_o (replacement index).
module tlb_lru_tracker
    import tlb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             touch_i,
    input  logic [IDX_W-1:0] touch_idx_i,
    input  logic [TLB_N-1:0] valid_i,
    output logic [IDX_W-1:0] victim_o
);

    logic [IDX_W-1:0] age_q [TLB_N];
    logic [IDX_W-1:0] age_d [TLB_N];
    logic [IDX_W-1:0] old_age;
    logic             found;

    // Touched entry becomes youngest; entries younger than its old
    // age shift one step older, so ages stay a permutation.
    always_comb begin
        age_d   = age_q;
        old_age = age_q[touch_idx_i];
        if (touch_i) begin
            for (int j = 0; j < TLB_N; j++) begin
                if (IDX_W'(j) == touch_idx_i) begin
                    age_d[j] = '0;
                end else if (age_q[j] < old_age) begin
                    age_d[j] = age_q[j] + IDX_W'(1);
                end
            end
        end
    end

    // Free slots fill lowest-index first; otherwise evict the oldest.
    always_comb begin
        victim_o = '0;
        found    = 1'b0;
        for (int j = 0; j < TLB_N; j++) begin
            if (!valid_i[j] && !found) begin
                victim_o = IDX_W'(j);
                found    = 1'b1;
            end
        end
        if (!found) begin
            for (int j = 0; j < TLB_N; j++) begin
                if (age_q[j] == IDX_W'(TLB_N - 1)) begin
                    victim_o = IDX_W'(j);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int j = 0; j < TLB_N; j++) begin
                age_q[j] <= IDX_W'(j);
            end
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/tlb_translator.sv
// Address translation stage: 4-entry TLB, 256-entry page table, timed walk.
// Ports: CPU request (req_valid/write_in/virt_addr), OS PT write and debug
// read, cache outputs (addr_prepared/rqst_addr), status tlb_hit/page_fault/busy.
module tlb_translator
    import tlb_pkg::*;
#(
    parameter int PT_LATENCY = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             write_in,
    input  logic [VA_W-1:0]  virt_addr,
    input  logic             pt_wr_en,
    input  logic [VPN_W-1:0] pt_wr_vpn,
    input  logic             pt_wr_valid,
    input  logic [PPN_W-1:0] pt_wr_ppn,
    input  logic [VPN_W-1:0] pt_rd_vpn,
    output logic [PTE_W-1:0] pt_rd_entry,
    output logic             addr_prepared,
    output logic [PA_W-1:0]  rqst_addr,
    output logic             tlb_hit,
    output logic             page_fault,
    output logic             busy
);

    tlb_state_e       state_q;
    tlb_entry_t       tlb_q [TLB_N];
    logic [PTE_W-1:0] pt_q  [PT_N];

    logic [VA_W-1:0]  va_q;
    logic             wr_q;
    logic             retry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PPN_W-1:0] walk_ppn_q;

    logic             prep_q;
    logic [PA_W-1:0]  addr_q;
    logic             hit_q;
    logic             pf_q;
    logic             busy_q;

    logic [VPN_W-1:0] va_vpn;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [TLB_N-1:0] valid_vec;
    logic             touch;
    logic [IDX_W-1:0] touch_idx;
    logic [IDX_W-1:0] victim_idx;
    tlb_entry_t       vic;
    logic [PTE_W-1:0] pte_walk;
    logic             walk_done;
    logic             wr_self;

    assign va_vpn    = va_q[VA_W-1:OFF_W];
    assign pte_walk  = pt_q[va_vpn];
    assign walk_done = (cnt_q == CNT_W'(PT_LATENCY - 1));
    assign vic       = tlb_q[victim_idx];
    assign wr_self   = pt_wr_en && (pt_wr_vpn == va_vpn);

    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        valid_vec = '0;
        for (int i = 0; i < TLB_N; i++) begin
            valid_vec[i] = tlb_q[i].v;
            if (tlb_q[i].v && tlb_q[i].vpn == va_vpn) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign touch = (state_q == ST_LOOKUP && hit) ||
                   (state_q == ST_REFILL);
    assign touch_idx = (state_q == ST_REFILL) ? victim_idx : hit_idx;

    tlb_lru_tracker u_lru (
        .clk_i       (clk),
        .rst_i       (reset),
        .touch_i     (touch),
        .touch_idx_i (touch_idx),
        .valid_i     (valid_vec),
        .victim_o    (victim_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            va_q       <= '0;
            wr_q       <= 1'b0;
            retry_q    <= 1'b0;
            cnt_q      <= '0;
            walk_ppn_q <= '0;
            prep_q     <= 1'b0;
            addr_q     <= '0;
            hit_q      <= 1'b0;
            pf_q       <= 1'b0;
            busy_q     <= 1'b0;
            for (int i = 0; i < TLB_N; i++) begin
                tlb_q[i] <= '0;
            end
            for (int p = 0; p < PT_N; p++) begin
                pt_q[p] <= '0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        va_q    <= virt_addr;
                        wr_q    <= write_in;
                        retry_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        tlb_q[hit_idx].r <= 1'b1;
                        if (wr_q) begin
                            tlb_q[hit_idx].d <= 1'b1;
                        end
                        addr_q  <= {tlb_q[hit_idx].ppn,
                                    va_q[OFF_W-1:0]};
                        prep_q  <= 1'b1;
                        hit_q   <= !retry_q;
                        state_q <= ST_RESPOND;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= ST_WALK;
                    end
                end
                ST_WALK: begin
                    if (walk_done) begin
                        if (pte_walk[PTE_V]) begin
                            walk_ppn_q <= pte_walk[PPN_W-1:0];
                            state_q    <= ST_REFILL;
                        end else begin
                            pf_q    <= 1'b1;
                            state_q <= ST_FAULT;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_REFILL: begin
                    if (vic.v) begin
                        pt_q[vic.vpn] <= pt_q[vic.vpn] |
                            make_pte(1'b0, vic.d, vic.r, '0);
                    end
                    // A same-edge PT write to this VPN makes the
                    // walked mapping stale, so it lands invalid.
                    tlb_q[victim_idx] <= '{
                        v:   !wr_self,
                        d:   1'b0,
                        r:   1'b0,
                        vpn: va_vpn,
                        ppn: walk_ppn_q
                    };
                    retry_q <= 1'b1;
                    state_q <= ST_LOOKUP;
                end
                ST_RESPOND: begin
                    if (!req_valid) begin
                        prep_q  <= 1'b0;
                        hit_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    if (!req_valid) begin
                        pf_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Later assignments override the write-back above.
            if (pt_wr_en) begin
                pt_q[pt_wr_vpn] <= make_pte(pt_wr_valid, 1'b0,
                                            1'b0, pt_wr_ppn);
                for (int i = 0; i < TLB_N; i++) begin
                    if (tlb_q[i].v && tlb_q[i].vpn == pt_wr_vpn &&
                        !(state_q == ST_REFILL &&
                          IDX_W'(i) == victim_idx)) begin
                        tlb_q[i].v <= 1'b0;
                    end
                end
            end
        end
    end

    assign pt_rd_entry   = pt_q[pt_rd_vpn];
    assign addr_prepared = prep_q;
    assign rqst_addr     = addr_q;
    assign tlb_hit       = hit_q;
    assign page_fault    = pf_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_tlb_translator.sv
// Scoreboard bench for tlb_translator: directed scenarios plus random
// requests and page-table writes checked against a queue-based model.
module tb_tlb_translator;
    localparam int L = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        write_in = 1'b0;
    logic [13:0] virt_addr = '0;
    logic        pt_wr_en = 1'b0;
    logic [7:0]  pt_wr_vpn = '0;
    logic        pt_wr_valid = 1'b0;
    logic [3:0]  pt_wr_ppn = '0;
    logic [7:0]  pt_rd_vpn = '0;
    logic [6:0]  pt_rd_entry;
    logic        addr_prepared;
    logic [9:0]  rqst_addr;
    logic        tlb_hit;
    logic        page_fault;
    logic        busy;

    tlb_translator #(.PT_LATENCY(L)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .write_in      (write_in),
        .virt_addr     (virt_addr),
        .pt_wr_en      (pt_wr_en),
        .pt_wr_vpn     (pt_wr_vpn),
        .pt_wr_valid   (pt_wr_valid),
        .pt_wr_ppn     (pt_wr_ppn),
        .pt_rd_vpn     (pt_rd_vpn),
        .pt_rd_entry   (pt_rd_entry),
        .addr_prepared (addr_prepared),
        .rqst_addr     (rqst_addr),
        .tlb_hit       (tlb_hit),
        .page_fault    (page_fault),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] vpn;
        logic [3:0] ppn;
        bit         d;
        bit         r;
    } ment_t;

    typedef struct {
        bit         fault;
        logic [9:0] addr;
        bit         hit;
        int         e0;
        int         lat;
    } exp_t;

    logic [6:0] pt_m [256];
    ment_t      tlb_m [$];
    exp_t       sb [$];
    exp_t       me;
    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         resp_cnt = 0;
    bit         seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    endtask

    // Model: PT array plus MRU-first list of cached mappings.
    task automatic model_reset();
        for (int i = 0; i < 256; i++) pt_m[i] = '0;
        tlb_m.delete();
    endtask

    task automatic model_ptw(input logic [7:0] vpn, input bit v,
                             input logic [3:0] ppn);
        pt_m[vpn] = {v, 2'b00, ppn};
        for (int i = tlb_m.size() - 1; i >= 0; i--)
            if (tlb_m[i].vpn == vpn) tlb_m.delete(i);
    endtask

    task automatic model_req(input logic [13:0] va, input bit wr,
                             output exp_t e);
        logic [7:0] vpn = va[13:6];
        int idx = -1;
        ment_t m;
        logic [6:0] pte;
        e.e0 = 0;
        for (int i = 0; i < tlb_m.size(); i++)
            if (tlb_m[i].vpn == vpn) idx = i;
        if (idx >= 0) begin
            m = tlb_m[idx];
            tlb_m.delete(idx);
            m.r = 1;
            if (wr) m.d = 1;
            tlb_m.push_front(m);
            e.fault = 0; e.addr = {m.ppn, va[5:0]};
            e.hit = 1; e.lat = 1;
        end else begin
            pte = pt_m[vpn];
            if (!pte[6]) begin
                e.fault = 1; e.addr = '0; e.hit = 0; e.lat = L + 1;
            end else begin
                if (tlb_m.size() == 4) begin
                    m = tlb_m.pop_back();
                    pt_m[m.vpn] = pt_m[m.vpn] | {1'b0, m.d, m.r, 4'b0};
                end
                m.vpn = vpn; m.ppn = pte[3:0]; m.d = wr; m.r = 1;
                tlb_m.push_front(m);
                e.fault = 0; e.addr = {pte[3:0], va[5:0]};
                e.hit = 0; e.lat = L + 3;
            end
        end
    endtask

    // Monitor: pops one expectation per response presented.
    always @(negedge clk) begin
        if (!reset) begin
            if ((addr_prepared || page_fault) && !seen) begin
                seen = 1'b1;
                resp_cnt++;
                chk("resp_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    me = sb.pop_front();
                    chk("page_fault", page_fault, me.fault);
                    if (me.fault) begin
                        chk("fault_noprep", addr_prepared, 0);
                    end else begin
                        chk("rqst_addr", rqst_addr, me.addr);
                        chk("tlb_hit", tlb_hit, me.hit);
                    end
                    chk("latency", cyc - me.e0, me.lat);
                end
            end else if (!addr_prepared && !page_fault) begin
                seen = 1'b0;
            end
        end
    end

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    endtask

    task automatic hw_reset(input bit check);
        @(negedge clk);
        reset = 1'b1;
        req_valid = 1'b0;
        pt_wr_en = 1'b0;
        #1;
        if (check) begin
            chk("rst_prep", addr_prepared, 0);
            chk("rst_pf", page_fault, 0);
            chk("rst_busy", busy, 0);
            chk("rst_addr", rqst_addr, 0);
            chk("rst_hit", tlb_hit, 0);
            chk("rst_pte", pt_rd_entry, 0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        sb.delete();
        seen = 1'b0;
    endtask

    task automatic pt_write(input logic [7:0] vpn, input bit v,
                            input logic [3:0] ppn);
        @(negedge clk);
        pt_wr_en = 1'b1; pt_wr_vpn = vpn;
        pt_wr_valid = v; pt_wr_ppn = ppn;
        @(negedge clk);
        pt_wr_en = 1'b0;
        model_ptw(vpn, v, ppn);
    endtask

    task automatic start_req(input logic [13:0] va, input bit wr);
        exp_t e;
        int st;
        int n;
        model_req(va, wr, e);
        @(negedge clk);
        req_valid = 1'b1; virt_addr = va; write_in = wr;
        e.e0 = cyc + 1;
        sb.push_back(e);
        st = resp_cnt;
        @(posedge clk);
        #1 chk("busy_rise", busy, 1);
        n = 0;
        while (resp_cnt == st && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (resp_cnt == st) begin
            n_chk++;
            $display("FAIL timeout: no response for va 0x%0h", va);
            finish_run();
        end
    endtask

    task automatic end_req();
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_prep", addr_prepared, 0);
        chk("idle_pf", page_fault, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] va;
        pt_rd_vpn = 8'h5A;
        hw_reset(1);

        // Miss then hit on VPN 0x12.
        pt_write(8'h12, 1, 4'h5);
        start_req(14'h0487, 0);
        chk("tp_miss_addr", rqst_addr, 10'h147);
        end_req();
        start_req(14'h0487, 0);
        chk("tp_hit_flag", tlb_hit, 1);
        end_req();

        // Shootdown, then a shootdown while the response is held.
        pt_write(8'h12, 1, 4'h9);
        start_req(14'h0487, 0);
        chk("tp_shoot_addr", rqst_addr, 10'h247);
        pt_write(8'h12, 1, 4'h9);
        chk("respond_hold", rqst_addr, 10'h247);
        chk("respond_prep", addr_prepared, 1);
        end_req();
        start_req(14'h0487, 1);
        end_req();

        // Unmapped page.
        start_req(14'h3FC0, 0);
        chk("tp_fault", page_fault, 1);
        end_req();

        // LRU eviction with dirty write-back.
        hw_reset(0);
        for (int v = 1; v <= 5; v++) pt_write(8'(v), 1, 4'(v + 8));
        start_req({8'd1, 6'h05}, 1);
        end_req();
        for (int v = 2; v <= 5; v++) begin
            start_req({8'(v), 6'h11}, 0);
            end_req();
        end
        pt_rd_vpn = 8'd1;
        #1;
        chk("wb_vpn1", pt_rd_entry, {3'b111, 4'd9});
        chk("wb_vpn1_model", pt_rd_entry, pt_m[1]);
        start_req({8'd1, 6'h05}, 0);
        end_req();

        // Reset two cycles into the walk.
        pt_write(8'h40, 1, 4'h3);
        @(negedge clk);
        req_valid = 1'b1; virt_addr = 14'h1003; write_in = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        pt_rd_vpn = 8'h40;
        #1;
        chk("mw_prep", addr_prepared, 0);
        chk("mw_pf", page_fault, 0);
        chk("mw_busy", busy, 0);
        chk("mw_addr", rqst_addr, 0);
        chk("mw_pte", pt_rd_entry, 0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        sb.delete();
        seen = 1'b0;
        pt_write(8'h40, 1, 4'h3);
        start_req(14'h1003, 0);
        end_req();

        // Random traffic over a small VPN set to force reuse.
        for (int k = 0; k < 160; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                pt_write(8'($urandom_range(0, 7)),
                         $urandom_range(0, 3) != 0,
                         4'($urandom));
            end else begin
                va = {5'd0, 3'($urandom_range(0, 7)), 6'($urandom)};
                start_req(va, 1'($urandom));
                end_req();
            end
            if (k % 8 == 0) begin
                pt_rd_vpn = 8'($urandom_range(0, 7));
                #1 chk("pt_rd", pt_rd_entry, pt_m[pt_rd_vpn]);
            end
        end

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        finish_run();
    end

endmodule
